// File: rtl/lfsr.sv
// Free-running maximal-length Fibonacci LFSR; shifts left with feedback into bit 0.
// Latency: out is the register itself and advances on every rising edge while rst=0.
// No backpressure: no enable or load, so the sequence never stalls.
module lfsr #(
  parameter int               WIDTH = 4,
  parameter logic [WIDTH-1:0] SEED  = WIDTH'(1)
) (
  input  logic             clk,
  input  logic             rst,
  output logic [WIDTH-1:0] out
);

  // Feedback tap masks for maximal-length polynomials, one per supported width.
  function automatic logic [15:0] tap_mask(input int w);
    logic [15:0] m;
    case (w)
      3:       m = 16'h0006;  // [2,1]
      4:       m = 16'h000C;  // [3,2]
      5:       m = 16'h0014;  // [4,2]
      6:       m = 16'h0030;  // [5,4]
      7:       m = 16'h0060;  // [6,5]
      8:       m = 16'h00B8;  // [7,5,4,3]
      9:       m = 16'h0110;  // [8,4]
      10:      m = 16'h0240;  // [9,6]
      11:      m = 16'h0500;  // [10,8]
      12:      m = 16'h0829;  // [11,5,3,0]
      13:      m = 16'h100D;  // [12,3,2,0]
      14:      m = 16'h2015;  // [13,4,2,0]
      15:      m = 16'h6000;  // [14,13]
      16:      m = 16'hD008;  // [15,14,12,3]
      default: m = 16'h0000;
    endcase
    return m;
  endfunction

  localparam logic [15:0]      TAP_ALL  = tap_mask(WIDTH);
  localparam logic [WIDTH-1:0] TAPS     = TAP_ALL[WIDTH-1:0];
  // An all-zero seed would lock the register up, so substitute 1.
  localparam logic [WIDTH-1:0] EFF_SEED = (SEED == '0) ? WIDTH'(1) : SEED;

  // Only widths with a table entry are meaningful.
  if (WIDTH < 3 || WIDTH > 16) begin : g_bad_width
    $error("lfsr: WIDTH must be in 3..16");
  end

  logic [WIDTH-1:0] r_state;
  logic             w_fb;
  logic             w_zero;

  // Feedback is the XOR of the tapped bits; zero detect drives the lock-up guard.
  always_comb begin
    w_fb   = ^(r_state & TAPS);
    w_zero = (r_state == '0);
  end

  // State register: reset wins, then zero-state recovery, otherwise shift left.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= EFF_SEED;
    end else if (w_zero) begin
      r_state <= EFF_SEED;
    end else begin
      r_state <= {r_state[WIDTH-2:0], w_fb};
    end
  end

  assign out = r_state;

endmodule

// File: tb/tb_lfsr.sv
// Bench for lfsr: table-driven reset/sequence vectors, corner sequences,
// randomized reset against a sequence-index model, and an 8-bit period check.
module tb_lfsr;

  logic       clk;
  logic       rst;
  logic [3:0] out4;
  logic [7:0] out8;

  int errors = 0;
  int checks = 0;

  lfsr #(.WIDTH(4), .SEED(4'b0001)) dut4 (.clk(clk), .rst(rst), .out(out4));
  lfsr #(.WIDTH(8), .SEED(8'h01))   dut8 (.clk(clk), .rst(rst), .out(out8));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference: the documented 15-state sequence; the model is just an index into it.
  logic [3:0] seq4 [15];
  int         idx;

  typedef struct {
    logic       rst;
    logic [3:0] exp;
    string      name;
  } vec_t;
  vec_t vecs [18];

  task automatic tick(input logic r);
    rst = r;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Model step: reset returns to the seed entry, otherwise walk forward cyclically.
  function automatic int next_idx(input int i, input logic r);
    return r ? 0 : (i + 1) % 15;
  endfunction

  logic [15:0] seen;
  logic [255:0] seen8;
  int  n;
  int  cnt;
  bit  found;
  bit  zero8;

  initial begin
    seq4 = '{4'b0001, 4'b0010, 4'b0100, 4'b1001, 4'b0011, 4'b0110, 4'b1101, 4'b1010,
             4'b0101, 4'b1011, 4'b0111, 4'b1111, 4'b1110, 4'b1100, 4'b1000};

    // Three reset edges, then 15 free-running edges wrapping back to the seed.
    for (int i = 0; i < 3; i++) vecs[i] = '{1'b1, 4'b0001, "reset_hold"};
    for (int i = 0; i < 15; i++) vecs[3 + i] = '{1'b0, seq4[(i + 1) % 15], "sequence"};

    rst = 1'b1;
    for (int i = 0; i < 18; i++) begin
      tick(vecs[i].rst);
      chk($sformatf("%s[%0d]", vecs[i].name, i), 16'(out4), 16'(vecs[i].exp));
    end
    idx = 0;

    // 1000 free-running cycles: never zero, every nonzero value once per 15-cycle window.
    seen = '0;
    for (int c = 0; c < 1000; c++) begin
      tick(1'b0);
      idx = next_idx(idx, 1'b0);
      if (out4 == 4'b0000) chk("free_run_zero", 16'(out4), 16'hFFFF);
      if (c % 100 == 0) chk("free_run_model", 16'(out4), 16'(seq4[idx]));
      seen[out4] = 1'b1;
      if (c % 15 == 14) begin
        chk("window_coverage", seen, 16'hFFFE);
        seen = '0;
      end
    end

    // Reset for one edge while out=1010, then shifting resumes from the seed.
    found = 1'b0;
    for (int c = 0; c < 20 && !found; c++) begin
      if (out4 == 4'b1010) found = 1'b1;
      else tick(1'b0);
    end
    chk("find_1010", 16'(found), 16'd1);
    tick(1'b1);
    chk("mid_reset", 16'(out4), 16'b0001);
    tick(1'b0);
    chk("after_mid_reset", 16'(out4), 16'b0010);

    // Lock-up guard: force the register to zero, then one edge recovers to the seed.
    force dut4.r_state = 4'b0000;
    #1;
    release dut4.r_state;
    chk("forced_zero", 16'(out4), 16'h0000);
    tick(1'b0);
    chk("guard_recover", 16'(out4), 16'b0001);
    tick(1'b0);
    chk("guard_continue", 16'(out4), 16'b0010);
    idx = 1;

    // Randomized reset pulses against the index model.
    for (int c = 0; c < 300; c++) begin
      logic r;
      r = ($urandom_range(0, 7) == 0);
      tick(r);
      idx = next_idx(idx, r);
      chk($sformatf("random[%0d]", c), 16'(out4), 16'(seq4[idx]));
    end

    // 8-bit instance: period exactly 255, never zero, every nonzero state visited.
    tick(1'b1);
    chk("w8_reset", 16'(out8), 16'h0001);
    seen8 = '0;
    seen8[1] = 1'b1;
    cnt   = 0;
    n     = 0;
    zero8 = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 300 && !found; c++) begin
      tick(1'b0);
      cnt++;
      if (out8 == 8'h00) zero8 = 1'b1;
      if (out8 == 8'h01) found = 1'b1;
      else if (!seen8[out8]) begin
        seen8[out8] = 1'b1;
        n++;
      end
    end
    chk("w8_period", 16'(cnt), 16'd255);
    chk("w8_no_zero", 16'(zero8), 16'd0);
    chk("w8_distinct", 16'(n + 1), 16'd255);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
